// File: rtl/vit_pkg.sv
// ---------------------------------------------------------------------------
// vit_pkg
// Shared definitions for the Viterbi frame controller:
//   - vit_state_e    : 3-bit frame FSM state encoding (6 of 8 codes used)
//   - vit_addr_width : address width needed to index FRAME_LEN symbols
// ---------------------------------------------------------------------------
package vit_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_BRCH = 3'd1,
    ST_ADD  = 3'd2,
    ST_MEM  = 3'd3,
    ST_TBCK = 3'd4,
    ST_DONE = 3'd5
  } vit_state_e;

  // Width needed for addresses 0..frame_len-1. Never narrower than one bit,
  // so the smallest legal frame (2 symbols) still gets a real address bus.
  function automatic int vit_addr_width(input int frame_len);
    return (frame_len <= 2) ? 1 : $clog2(frame_len);
  endfunction

endpackage

// File: rtl/vit_addr_cnt.sv
// ---------------------------------------------------------------------------
// vit_addr_cnt
// AW-bit address counter with clear / load / step and a terminal flag.
// Direction is fixed at elaboration (COUNT_UP). Priority: clr > load > step.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset (count -> 0)
//   clr       : synchronous clear to 0
//   load      : synchronous load of load_val
//   step      : advance by one in the configured direction
//   load_val  : value taken on load
//   cnt       : registered count
//   term      : cnt equals TERM_VAL
// ---------------------------------------------------------------------------
module vit_addr_cnt
  import vit_pkg::*;
#(
  parameter int            AW       = 4,
  parameter bit            COUNT_UP = 1'b1,
  parameter logic [AW-1:0] TERM_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] cnt,
  output logic          term
);

  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (step) begin
      cnt_d = COUNT_UP ? (cnt_q + AW'(1)) : (cnt_q - AW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == TERM_VAL);

endmodule

// File: rtl/vit_frame_ctrl.sv
// ---------------------------------------------------------------------------
// vit_frame_ctrl
// Frame-level sequencer for the Viterbi datapath. One accepted start runs
// BRCH -> ADD -> MEM (FRAME_LEN cycles, wr_addr 0..N-1) -> TBCK (FRAME_LEN
// cycles, tb_addr N-1..0) -> DONE. Starting again from DONE skips IDLE.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   en                : advance qualifier (0 = stall everything)
//   start             : frame request, honoured in IDLE and DONE only
//   abort             : synchronous return to IDLE, ignores en
//   en_brch/add/mem/tbck : stage enables, Moore-decoded from state
//   wr_addr, tb_addr  : registered survivor write / traceback read addresses
//   busy, done        : host handshake (busy = not IDLE, done = DONE state)
// ---------------------------------------------------------------------------
module vit_frame_ctrl
  import vit_pkg::*;
#(
  parameter  int FRAME_LEN = 12,
  localparam int AW        = vit_addr_width(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic          abort,
  output logic          en_brch,
  output logic          en_add,
  output logic          en_mem,
  output logic          en_tbck,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] tb_addr,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

  vit_state_e state_q;
  vit_state_e state_d;

  logic wr_clr, wr_inc, wr_term;
  logic tb_clr, tb_load, tb_dec, tb_term;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and counter controls.
  always_comb begin
    state_d = state_q;
    wr_clr  = 1'b0;
    wr_inc  = 1'b0;
    tb_clr  = 1'b0;
    tb_load = 1'b0;
    tb_dec  = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      wr_clr  = 1'b1;
      tb_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en && start) begin
            state_d = ST_BRCH;
            wr_clr  = 1'b1;
          end
        end
        ST_BRCH: if (en) state_d = ST_ADD;
        ST_ADD:  if (en) state_d = ST_MEM;
        ST_MEM: begin
          if (en) begin
            // Last survivor column written: wr_addr stays at N-1.
            if (wr_term) begin
              state_d = ST_TBCK;
              tb_load = 1'b1;
            end else begin
              wr_inc = 1'b1;
            end
          end
        end
        ST_TBCK: begin
          if (en) begin
            if (tb_term) begin
              state_d = ST_DONE;
            end else begin
              tb_dec = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (en) begin
            if (start) begin
              state_d = ST_BRCH;
              wr_clr  = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        // Corrupted encodings recover regardless of en.
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Moore output decode.
  always_comb begin
    en_brch = 1'b0;
    en_add  = 1'b0;
    en_mem  = 1'b0;
    en_tbck = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_BRCH: begin en_brch = 1'b1; busy = 1'b1; end
      ST_ADD:  begin en_brch = 1'b1; en_add = 1'b1; busy = 1'b1; end
      ST_MEM:  begin en_brch = 1'b1; en_add = 1'b1; en_mem = 1'b1; busy = 1'b1; end
      ST_TBCK: begin en_mem = 1'b1; en_tbck = 1'b1; busy = 1'b1; end
      ST_DONE: begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  vit_addr_cnt #(
    .AW       (AW),
    .COUNT_UP (1'b1),
    .TERM_VAL (LAST_ADDR)
  ) u_wr_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (wr_clr),
    .load     (1'b0),
    .step     (wr_inc),
    .load_val ('0),
    .cnt      (wr_addr),
    .term     (wr_term)
  );

  vit_addr_cnt #(
    .AW       (AW),
    .COUNT_UP (1'b0),
    .TERM_VAL ('0)
  ) u_tb_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (tb_clr),
    .load     (tb_load),
    .step     (tb_dec),
    .load_val (LAST_ADDR),
    .cnt      (tb_addr),
    .term     (tb_term)
  );

endmodule

// File: tb/tb_vit_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vit_frame_ctrl
// Three controllers (FRAME_LEN = 12, 2, 16) share one stimulus stream. Each is
// compared every cycle against a frame-phase model: the phase p counts
// enabled cycles since the start was accepted, and the expected outputs are
// computed from p with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_vit_frame_ctrl;

  logic clk     = 1'b0;
  logic clk_run = 1'b1;
  logic rst_n   = 1'b1;
  logic en      = 1'b0;
  logic start   = 1'b0;
  logic abort   = 1'b0;

  int n_run  = 0;
  int n_fail = 0;

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // ---------------- DUT instances ----------------
  logic       b12, a12, m12, t12, busy12, done12;
  logic [3:0] wr12, tb12;
  logic       b2, a2, m2, t2, busy2, done2;
  logic [0:0] wr2, tb2;
  logic       b16, a16, m16, t16, busy16, done16;
  logic [3:0] wr16, tb16;

  vit_frame_ctrl #(.FRAME_LEN(12)) u12 (
    .clk(clk), .rst(rst_n), .en(en), .start(start), .abort(abort),
    .en_brch(b12), .en_add(a12), .en_mem(m12), .en_tbck(t12),
    .wr_addr(wr12), .tb_addr(tb12), .busy(busy12), .done(done12));

  vit_frame_ctrl #(.FRAME_LEN(2)) u2 (
    .clk(clk), .rst(rst_n), .en(en), .start(start), .abort(abort),
    .en_brch(b2), .en_add(a2), .en_mem(m2), .en_tbck(t2),
    .wr_addr(wr2), .tb_addr(tb2), .busy(busy2), .done(done2));

  vit_frame_ctrl #(.FRAME_LEN(16)) u16 (
    .clk(clk), .rst(rst_n), .en(en), .start(start), .abort(abort),
    .en_brch(b16), .en_add(a16), .en_mem(m16), .en_tbck(t16),
    .wr_addr(wr16), .tb_addr(tb16), .busy(busy16), .done(done16));

  // Observed vector: [15:12] brch/add/mem/tbck, [11] busy, [10] done,
  // [9:5] wr_addr, [4:0] tb_addr (addresses zero-extended).
  logic [15:0] obs [3];
  assign obs[0] = {b12, a12, m12, t12, busy12, done12, 1'b0, wr12, 1'b0, tb12};
  assign obs[1] = {b2,  a2,  m2,  t2,  busy2,  done2,  4'b0, wr2,  4'b0, tb2};
  assign obs[2] = {b16, a16, m16, t16, busy16, done16, 1'b0, wr16, 1'b0, tb16};

  // ---------------- reference model ----------------
  int flen [3] = '{12, 2, 16};
  int p_m  [3];        // 0 = idle, 1..2F+3 = phase within frame
  int widle_m [3];     // wr_addr left behind while idle

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n || abort) begin
        p_m[i]     <= 0;
        widle_m[i] <= 0;
      end else if (en) begin
        if (p_m[i] == 0) begin
          if (start) p_m[i] <= 1;
        end else if (p_m[i] == 2 * flen[i] + 3) begin
          if (start) begin
            p_m[i] <= 1;
          end else begin
            p_m[i]     <= 0;
            widle_m[i] <= flen[i] - 1;
          end
        end else begin
          p_m[i] <= p_m[i] + 1;
        end
      end
    end
  end

  function automatic logic [15:0] exp_vec(input int i);
    int f, p, wr, tb;
    logic [3:0] e4;
    logic b, d;
    f = flen[i]; p = p_m[i];
    tb = 0; b = 1'b1; d = 1'b0;
    if (p == 0) begin
      e4 = 4'b0000; b = 1'b0; wr = widle_m[i];
    end else if (p == 1) begin
      e4 = 4'b1000; wr = 0;
    end else if (p == 2) begin
      e4 = 4'b1100; wr = 0;
    end else if (p <= f + 2) begin
      e4 = 4'b1110; wr = p - 3;
    end else if (p <= 2 * f + 2) begin
      e4 = 4'b0011; wr = f - 1; tb = 2 * f + 2 - p;
    end else begin
      e4 = 4'b0000; d = 1'b1; wr = f - 1;
    end
    return {e4, b, d, wr[4:0], tb[4:0]};
  endfunction

  // Return all instances to IDLE between scenarios.
  task automatic settle();
    start = 1'b0; en = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; en = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int guard;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_run++;
      if (obs[i] !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_state inst=%0d got=%h exp=%h", i, obs[i], 16'h0000);
      end
    end
    // Run into MEM, then reset with the clock stopped.
    en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(m12 === 1'b1 && t12 === 1'b0 && wr12 === 4'd4) && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    n_run++;
    if (guard >= 30) begin
      n_fail++;
      $display("FAIL reset_reach_mem got=timeout exp=wr_addr 4 in MEM");
    end
    clk_run = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_run++;
      if (obs[i] !== 16'h0000) begin
        n_fail++;
        $display("FAIL async_reset inst=%0d got=%h exp=%h", i, obs[i], 16'h0000);
      end
    end
    #3 rst_n = 1'b1;
    clk_run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_run++;
      if (obs[i] !== 16'h0000 || obs[i] !== exp_vec(i)) begin
        n_fail++;
        $display("FAIL post_reset_idle inst=%0d got=%h exp=%h", i, obs[i], exp_vec(i));
      end
    end
  endtask

  task automatic test_nominal();
    int dcyc [3];
    int dcnt [3];
    int exp_d;
    dcyc = '{0, 0, 0}; dcnt = '{0, 0, 0};
    en = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 38; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        n_run++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL nominal inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], exp_vec(i));
        end
        if (obs[i][10] === 1'b1) begin
          dcnt[i]++;
          if (dcyc[i] == 0) dcyc[i] = cyc;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      exp_d = 2 * flen[i] + 3;
      n_run++;
      if (dcyc[i] != exp_d || dcnt[i] != 1) begin
        n_fail++;
        $display("FAIL done_cycle F=%0d got=cyc %0d (x%0d) exp=cyc %0d (x1)", flen[i], dcyc[i], dcnt[i], exp_d);
      end
    end
  endtask

  task automatic test_stall();
    int dcyc;
    int left;
    bit stalled;
    dcyc = 0; left = 0; stalled = 1'b0;
    en = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 44; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        n_run++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL stall inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], exp_vec(i));
        end
      end
      if (done12 === 1'b1 && dcyc == 0) dcyc = cyc;
      if (left > 0) begin
        n_run++;
        if (wr12 !== 4'd5 || m12 !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_hold cyc=%0d got=wr %0d mem %b exp=wr 5 mem 1", cyc, wr12, m12);
        end
        left--;
        if (left == 0) en = 1'b1;
      end else if (!stalled && cyc == 8) begin
        en = 1'b0; left = 3; stalled = 1'b1;
      end
    end
    n_run++;
    if (dcyc != 30) begin
      n_fail++;
      $display("FAIL stall_done_cycle got=cyc %0d exp=cyc 30", dcyc);
    end
  endtask

  task automatic test_abort();
    int guard;
    int dcyc;
    en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(t12 === 1'b1 && tb12 === 4'd7) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    n_run++;
    if (guard >= 40) begin
      n_fail++;
      $display("FAIL abort_reach_tbck got=timeout exp=tb_addr 7 in TBCK");
    end
    en = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_run++;
      if (obs[i] !== 16'h0000) begin
        n_fail++;
        $display("FAIL abort_idle inst=%0d got=%h exp=%h", i, obs[i], 16'h0000);
      end
    end
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      n_run++;
      if (done12 !== 1'b0 || busy12 !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done cyc=%0d got=done %b busy %b exp=0 0", cyc, done12, busy12);
      end
    end
    dcyc = 0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      n_run++;
      if (obs[0] !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL abort_restart cyc=%0d got=%h exp=%h", cyc, obs[0], exp_vec(0));
      end
      if (done12 === 1'b1 && dcyc == 0) dcyc = cyc;
    end
    n_run++;
    if (dcyc != 27) begin
      n_fail++;
      $display("FAIL abort_restart_done got=cyc %0d exp=cyc 27", dcyc);
    end
  endtask

  task automatic test_back_to_back();
    int idle_cnt;
    int done_cnt;
    idle_cnt = 0; done_cnt = 0;
    en = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_run++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL b2b inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], exp_vec(i));
        end
      end
      if (cyc <= 54 && busy12 !== 1'b1) idle_cnt++;
      if (done12 === 1'b1) done_cnt++;
      if (cyc == 28) begin
        n_run++;
        if (b12 !== 1'b1 || a12 !== 1'b0 || busy12 !== 1'b1 || wr12 !== 4'd0) begin
          n_fail++;
          $display("FAIL b2b_restart got=brch %b add %b busy %b wr %0d exp=1 0 1 0", b12, a12, busy12, wr12);
        end
      end
      // Start held during MEM (ignored) and again during DONE (taken).
      start = ((cyc >= 5 && cyc <= 8) || cyc == 27) ? 1'b1 : 1'b0;
    end
    n_run++;
    if (idle_cnt != 0 || done_cnt != 2) begin
      n_fail++;
      $display("FAIL b2b_summary got=idle %0d done %0d exp=idle 0 done 2", idle_cnt, done_cnt);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_run++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL random inst=%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], exp_vec(i));
        end
      end
      en    = ($urandom_range(3, 0) != 0);
      start = ($urandom_range(2, 0) == 0);
      abort = ($urandom_range(39, 0) == 0);
    end
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    settle();
    test_nominal();
    settle();
    test_stall();
    settle();
    test_abort();
    settle();
    test_back_to_back();
    settle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
